drlp_sld_ctrl: RTL and testbench
================================

Name: drlp_sld_ctrl

Overview:
Sequencer for the sliding-window register file (drlp_sld_rf) of one DRLP core. It reads input-buffer columns (one 6-pixel column word per address) and drives the RF shift strobe, mode and 3x3 select. It tells the PE array when the 6x6 window holds a complete kernel footprint, then waits for the array to consume it. It runs one feature-map pass per start pulse: cfg_rows stripes of cfg_width columns each.

Parameters:
ADDR_WIDTH, 12, input-buffer address width
COL_WIDTH, 8, width of column/row counters and cfg_width/cfg_rows
STRIDE_WIDTH, 3, width of cfg_fill and cfg_stride
RD_LAT, 1, input-buffer read latency in cycles (1 or 2 supported)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  pulse; latch cfg_* and begin a pass (ignored while o_busy)
i_cfg_base  in  ADDR_WIDTH  first buffer address of the pass
i_cfg_width  in  COL_WIDTH  columns per stripe (>=1)
i_cfg_rows  in  COL_WIDTH  stripes per pass (>=1)
i_cfg_fill  in  STRIDE_WIDTH  shifts before first window of a stripe (1..6)
i_cfg_stride  in  STRIDE_WIDTH  shifts between windows (1..6)
i_cfg_mode  in  2  RF shift mode for the pass
i_cfg_3x3  in  1  RF 3x3 half select for the pass
o_rd_en  out  1  input-buffer read strobe
o_rd_addr  out  ADDR_WIDTH  input-buffer read address
o_shift  out  1  RF shift strobe, aligned with returning read data
o_mode  out  2  RF mode (latched cfg)
o_3x3  out  1  RF 3x3 select (latched cfg)
o_win_valid  out  1  RF window complete, held until accepted
i_win_ready  in  1  PE array accepts window
o_busy  out  1  pass in progress
o_done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; in-flight reads discarded. Reset mid-pass aborts with no o_done.
- States: IDLE, FILL, SLIDE, DRAIN, WAIT, DONE.
- IDLE: on i_start, latch cfg, row=0, col=0, go FILL; o_busy=1 from the next cycle.
- FILL: issue cfg_fill consecutive reads, one per cycle, at addr = base + row*width + col; col increments per read. Then go DRAIN.
- SLIDE: issue cfg_stride consecutive reads, same addressing. Then go DRAIN.
- DRAIN: wait until every issued read has returned. Go WAIT once the last shift has been applied.
- Read/shift pipeline: o_shift = o_rd_en delayed RD_LAT cycles. No read is issued outside FILL/SLIDE, so the RF never shifts while a window is pending.
- WAIT: o_win_valid=1 while i_win_ready is low. The RF content is stable.
- On o_win_valid&&i_win_ready:
  - if col+stride <= width, go SLIDE;
  - else if row+1 < rows, row++, col=0, go FILL;
  - else go DONE.
- DONE: o_done=1 for one cycle, o_busy=0, go IDLE.
- Windows per stripe = floor((width-fill)/stride)+1; trailing columns beyond the last full stride are never read.
- If fill > width: the stripe produces no window; the controller skips straight to the next row/DONE after FILL with col=width reads only.
- Address arithmetic is modulo 2^ADDR_WIDTH (wrap allowed, not flagged).
- o_mode/o_3x3 hold their latched values until the next start.
- i_start while busy is ignored. i_start in the same cycle as DONE is ignored; start is accepted only in IDLE.
- cfg_stride=0 or cfg_fill=0 is illegal. The block treats either as 1.

Optional Feature:
DRLP_SLD_PERF_EN
- With it: adds o_stall_cnt (32 bit), counting WAIT cycles with i_win_ready=0, and o_win_cnt (32 bit), counting accepted windows. Both clear on i_start and i_rst and are held after DONE.
- Without it: neither port nor the counters exist.

Decomposition:
- Shared package drlp_pkg: state encoding localparams, RF mode codes (2'b00..2'b11), RD_LAT limit.
- One natural sub-module, drlp_sld_rdpipe: RD_LAT-deep rd_en->shift delay line with an in-flight counter. It gives the "drained" flag to the FSM.

Test Plan:
- width=8, rows=2, fill=3, stride=1, base=0, ready tied 1: addresses 0..15 read once each; 12 o_win_valid cycles (6 per stripe); o_done once; o_shift count=16.
- width=8, rows=1, fill=3, stride=2: reads addr 0..6 only (7 reads); 3 windows; addr 7 never read.
- Backpressure: ready held 0 for 10 cycles on the 2nd window: o_win_valid stays 1; no o_rd_en/o_shift during the stall; resumes with the next read at the correct address.
- RD_LAT=2, fill=6, stride=1: o_shift trails o_rd_en by exactly 2 cycles; window 1 asserted only after the 6th shift.
- i_rst asserted mid-SLIDE: next cycle all outputs 0; no o_done; a fresh i_start restarts from base.
- fill=5, width=4: zero windows; o_done asserted after 4 reads; i_start during busy ignored.

Source files
------------

// File: rtl/drlp_pkg.sv
// drlp_pkg: shared state encoding, RF mode codes and read-latency limit
// for the DRLP sliding-window path.
package drlp_pkg;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_SLIDE = 3'd2,
        S_DRAIN = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } sld_state_e;
    localparam logic [1:0] RF_MODE_M0 = 2'b00;
    localparam logic [1:0] RF_MODE_M1 = 2'b01;
    localparam logic [1:0] RF_MODE_M2 = 2'b10;
    localparam logic [1:0] RF_MODE_M3 = 2'b11;
    localparam int RD_LAT_MAX = 2;
endpackage

// File: rtl/drlp_sld_rdpipe.sv
// drlp_sld_rdpipe: RD_LAT-deep read-strobe to shift-strobe delay line with
// an in-flight read counter that tells the sequencer when all data has landed.
module drlp_sld_rdpipe
    import drlp_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rd_en,
    output logic o_shift,
    output logic o_drained
);
    localparam int CW = $clog2(RD_LAT_MAX + 1);
    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [CW-1:0]     inflight_q, inflight_d;

    // The concatenation drops its top bit, so this also covers RD_LAT == 1.
    assign pipe_d     = RD_LAT'({pipe_q, i_rd_en});
    assign o_shift    = pipe_q[RD_LAT-1];
    assign inflight_d = inflight_q + CW'(i_rd_en) - CW'(o_shift);
    // Drained means the shift applied this cycle was the last outstanding one.
    assign o_drained  = inflight_d == '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pipe_q     <= '0;
            inflight_q <= '0;
        end else begin
            pipe_q     <= pipe_d;
            inflight_q <= inflight_d;
        end
    end
endmodule

// File: rtl/drlp_sld_ctrl.sv
// drlp_sld_ctrl: sliding-window RF sequencer; reads buffer columns, strobes RF
// shifts and hands complete windows to the PE array. DRLP_SLD_PERF_EN adds perf counters.
module drlp_sld_ctrl
    import drlp_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int COL_WIDTH    = 8,
    parameter int STRIDE_WIDTH = 3,
    parameter int RD_LAT       = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_cfg_base,
    input  logic [COL_WIDTH-1:0]    i_cfg_width,
    input  logic [COL_WIDTH-1:0]    i_cfg_rows,
    input  logic [STRIDE_WIDTH-1:0] i_cfg_fill,
    input  logic [STRIDE_WIDTH-1:0] i_cfg_stride,
    input  logic [1:0]              i_cfg_mode,
    input  logic                    i_cfg_3x3,
    output logic                    o_rd_en,
    output logic [ADDR_WIDTH-1:0]   o_rd_addr,
    output logic                    o_shift,
    output logic [1:0]              o_mode,
    output logic                    o_3x3,
    output logic                    o_win_valid,
    input  logic                    i_win_ready,
    output logic                    o_busy,
`ifdef DRLP_SLD_PERF_EN
    output logic [31:0]             o_stall_cnt,
    output logic [31:0]             o_win_cnt,
`endif
    output logic                    o_done
);
    sld_state_e              state_q, state_d;
    logic [COL_WIDTH-1:0]    width_q, rows_q, row_q, row_d, col_q, col_d;
    logic [ADDR_WIDTH-1:0]   base_q, row_base_q, row_base_d;
    logic [STRIDE_WIDTH-1:0] fill_q, stride_q, cnt_q, cnt_d, phase_len;
    logic [1:0]              mode_q;
    logic                    sel3_q, start_ok, rd_en, drained, last_rd;
    logic                    no_win, more_rows, can_slide, accept, next_row;

    assign start_ok  = (state_q == S_IDLE) && i_start;
    assign rd_en     = (state_q == S_FILL) || (state_q == S_SLIDE);
    assign phase_len = (state_q == S_FILL) ? fill_q : stride_q;
    // A fill wider than the stripe stops at the last column.
    assign last_rd   = (cnt_q + STRIDE_WIDTH'(1) == phase_len) || (32'(col_q) + 1 >= 32'(width_q));
    assign no_win    = 32'(fill_q) > 32'(width_q);
    assign more_rows = 32'(row_q) + 1 < 32'(rows_q);
    assign can_slide = 32'(col_q) + 32'(stride_q) <= 32'(width_q);
    assign accept    = (state_q == S_WAIT) && i_win_ready;
    assign next_row  = more_rows && (accept ? !can_slide : (state_q == S_DRAIN) && drained && no_win);

    drlp_sld_rdpipe #(.RD_LAT(RD_LAT)) u_rdpipe (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_rd_en   (rd_en),
        .o_shift   (o_shift),
        .o_drained (drained)
    );

    always_ff @(posedge i_clk) begin
        state_q <= i_rst ? S_IDLE : state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:          state_d = i_start ? S_FILL : S_IDLE;
            S_FILL, S_SLIDE: state_d = last_rd ? S_DRAIN : state_q;
            S_DRAIN:         state_d = !drained ? S_DRAIN : !no_win ? S_WAIT : more_rows ? S_FILL : S_DONE;
            S_WAIT:          state_d = !i_win_ready ? S_WAIT : can_slide ? S_SLIDE : more_rows ? S_FILL : S_DONE;
            default:         state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_rd_en     = rd_en;
        o_rd_addr   = rd_en ? base_q + row_base_q + ADDR_WIDTH'(col_q) : '0;
        o_win_valid = state_q == S_WAIT;
        o_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        o_done      = state_q == S_DONE;
    end

    assign o_mode = mode_q;
    assign o_3x3  = sel3_q;

    // Zero fill/stride are illegal; clamp to one so the pass still terminates.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            base_q   <= '0;
            width_q  <= '0;
            rows_q   <= '0;
            fill_q   <= '0;
            stride_q <= '0;
            mode_q   <= '0;
            sel3_q   <= 1'b0;
        end else if (start_ok) begin
            base_q   <= i_cfg_base;
            width_q  <= i_cfg_width;
            rows_q   <= i_cfg_rows;
            fill_q   <= (i_cfg_fill == '0) ? STRIDE_WIDTH'(1) : i_cfg_fill;
            stride_q <= (i_cfg_stride == '0) ? STRIDE_WIDTH'(1) : i_cfg_stride;
            mode_q   <= i_cfg_mode;
            sel3_q   <= i_cfg_3x3;
        end
    end

    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        row_base_d = row_base_q;
        if (state_q == S_IDLE) begin
            row_d      = '0;
            col_d      = '0;
            cnt_d      = '0;
            row_base_d = '0;
        end else if (rd_en) begin
            col_d = col_q + COL_WIDTH'(1);
            cnt_d = last_rd ? '0 : cnt_q + STRIDE_WIDTH'(1);
        end else if (next_row) begin
            row_d      = row_q + COL_WIDTH'(1);
            col_d      = '0;
            row_base_d = row_base_q + ADDR_WIDTH'(width_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            row_base_q <= '0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            row_base_q <= row_base_d;
        end
    end

`ifdef DRLP_SLD_PERF_EN
    logic [31:0] stall_q, wins_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || start_ok) begin
            stall_q <= '0;
            wins_q  <= '0;
        end else begin
            stall_q <= stall_q + 32'((state_q == S_WAIT) && !i_win_ready);
            wins_q  <= wins_q + 32'(accept);
        end
    end

    assign o_stall_cnt = stall_q;
    assign o_win_cnt   = wins_q;
`endif
endmodule

// File: tb/tb_drlp_sld_ctrl.sv
// tb_drlp_sld_ctrl: directed vector table plus hand sequences for backpressure,
// read latency 2, mid-pass reset and ignored starts.
module tb_drlp_sld_ctrl;
    typedef struct {
        logic [11:0] base;
        logic [7:0]  w;
        logic [7:0]  r;
        logic [2:0]  f;
        logic [2:0]  s;
        int          rd;
        int          win;
        int          last;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, start1 = 1'b0, start2 = 1'b0, ready1 = 1'b1, cfg3 = 1'b0;
    logic [11:0] base = '0;
    logic [7:0]  width = '0, rows = '0;
    logic [2:0]  fill = '0, stride = '0;
    logic [1:0]  mode = '0;

    logic        rd_en1, shift1, s3o1, win1, busy1, done1;
    logic [11:0] rd_addr1;
    logic [1:0]  mode1;
    logic        rd_en2, shift2, s3o2, win2, busy2, done2;
    logic [11:0] rd_addr2;
    logic [1:0]  mode2;

    drlp_sld_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_cfg_base(base), .i_cfg_width(width),
        .i_cfg_rows(rows), .i_cfg_fill(fill), .i_cfg_stride(stride), .i_cfg_mode(mode),
        .i_cfg_3x3(cfg3), .o_rd_en(rd_en1), .o_rd_addr(rd_addr1), .o_shift(shift1),
        .o_mode(mode1), .o_3x3(s3o1), .o_win_valid(win1), .i_win_ready(ready1),
        .o_busy(busy1), .o_done(done1)
    );

    drlp_sld_ctrl #(.RD_LAT(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_cfg_base(base), .i_cfg_width(width),
        .i_cfg_rows(rows), .i_cfg_fill(fill), .i_cfg_stride(stride), .i_cfg_mode(mode),
        .i_cfg_3x3(cfg3), .o_rd_en(rd_en2), .o_rd_addr(rd_addr2), .o_shift(shift2),
        .o_mode(mode2), .o_3x3(s3o2), .o_win_valid(win2), .i_win_ready(1'b1),
        .o_busy(busy2), .o_done(done2)
    );

    int checks = 0, failures = 0;
    int n_rd = 0, n_sh = 0, n_win = 0, n_done = 0, addr_err = 0, pass_id = 0, last_pass = 0;
    int n_rd2 = 0, n_sh2 = 0, n_win2 = 0, lag_err = 0, sh_first = -1;
    logic [11:0] last_addr = '0, exp_addr = '0, mon_base = '0;
    logic [1:0]  rd2_hist = '0;

    always @(negedge clk) begin
        if (pass_id != last_pass) begin
            exp_addr  = mon_base;
            last_pass = pass_id;
        end
        if (rd_en1) begin
            if (rd_addr1 != exp_addr) addr_err++;
            exp_addr++;
            last_addr = rd_addr1;
            n_rd++;
        end
        if (shift1) n_sh++;
        if (win1) n_win++;
        if (done1) n_done++;
        if (shift2 != rd2_hist[1]) lag_err++;
        rd2_hist = {rd2_hist[0], rd_en2};
        if (win2 && sh_first < 0) sh_first = n_sh2;
        if (rd_en2) n_rd2++;
        if (shift2) n_sh2++;
        if (win2) n_win2++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input logic [11:0] b, input logic [7:0] w, input logic [7:0] r,
                       input logic [2:0] f, input logic [2:0] st);
        @(negedge clk);
        base = b; width = w; rows = r; fill = f; stride = st;
        start1 = 1'b1; pass_id++; mon_base = b;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i = 0;
        while (!done1 && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_done_seen"}, int'(done1), 1);
    endtask

    task automatic wait_win(input string name);
        int i = 0;
        while (!win1 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_win_seen"}, int'(win1), 1);
    endtask

    vec_t vecs[6];
    int   s_rd, s_sh, s_win, s_done, s_err, bad;

    initial begin
        vecs[0] = '{12'd0,    8'd8, 8'd2, 3'd3, 3'd1, 16, 12, 15};
        vecs[1] = '{12'd0,    8'd8, 8'd1, 3'd3, 3'd2,  7,  3,  6};
        vecs[2] = '{12'd0,    8'd4, 8'd1, 3'd5, 3'd1,  4,  0,  3};
        vecs[3] = '{12'd100,  8'd5, 8'd3, 3'd2, 3'd3, 15,  6, 114};
        vecs[4] = '{12'd0,    8'd3, 8'd1, 3'd0, 3'd0,  3,  3,  2};
        vecs[5] = '{12'd4094, 8'd4, 8'd1, 3'd4, 3'd1,  4,  1,  1};

        repeat (3) @(negedge clk);
        chk("reset_outs", int'({rd_en1, rd_addr1, shift1, mode1, s3o1, win1, busy1, done1}), 0);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            s_rd = n_rd; s_sh = n_sh; s_win = n_win; s_done = n_done; s_err = addr_err;
            run(vecs[k].base, vecs[k].w, vecs[k].r, vecs[k].f, vecs[k].s);
            wait_done($sformatf("v%0d", k));
            @(negedge clk);
            chk($sformatf("v%0d_reads", k), n_rd - s_rd, vecs[k].rd);
            chk($sformatf("v%0d_shifts", k), n_sh - s_sh, vecs[k].rd);
            chk($sformatf("v%0d_wins", k), n_win - s_win, vecs[k].win);
            chk($sformatf("v%0d_dones", k), n_done - s_done, 1);
            chk($sformatf("v%0d_addr_err", k), addr_err - s_err, 0);
            chk($sformatf("v%0d_last_addr", k), int'(last_addr), vecs[k].last);
        end

        // Backpressure on the second window.
        ready1 = 1'b0;
        s_err = addr_err;
        run(12'd0, 8'd8, 8'd1, 3'd3, 3'd1);
        wait_win("bp1");
        ready1 = 1'b1;
        @(negedge clk);
        ready1 = 1'b0;
        wait_win("bp2");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!win1 || rd_en1 || shift1) bad++;
        end
        chk("bp_stall_hold", bad, 0);
        ready1 = 1'b1;
        @(negedge clk);
        chk("bp_resume_rd", int'(rd_en1), 1);
        chk("bp_resume_addr", int'(rd_addr1), 4);
        wait_done("bp");
        @(negedge clk);
        chk("bp_addr_err", addr_err - s_err, 0);

        // Read latency 2 on the second instance.
        @(negedge clk);
        base = '0; width = 8'd8; rows = 8'd1; fill = 3'd6; stride = 3'd1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        bad = 0;
        while (!done2 && bad < 500) begin
            @(negedge clk);
            bad++;
        end
        chk("lat2_done_seen", int'(done2), 1);
        @(negedge clk);
        chk("lat2_reads", n_rd2, 8);
        chk("lat2_shifts", n_sh2, 8);
        chk("lat2_wins", n_win2, 3);
        chk("lat2_lag_err", lag_err, 0);
        chk("lat2_shifts_before_win", sh_first, 6);

        // Reset in the middle of a slide.
        mode = 2'b10; cfg3 = 1'b1;
        run(12'd0, 8'd8, 8'd1, 3'd3, 3'd1);
        chk("mode_latched", int'(mode1), 2);
        chk("sel3_latched", int'(s3o1), 1);
        bad = 0;
        while (!(rd_en1 && rd_addr1 == 12'd5) && bad < 100) begin
            @(negedge clk);
            bad++;
        end
        chk("midrst_slide_seen", int'(rd_en1 && rd_addr1 == 12'd5), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outs", int'({rd_en1, rd_addr1, shift1, mode1, s3o1, win1, busy1, done1}), 0);
        rst = 1'b0;
        s_done = n_done;
        repeat (10) @(negedge clk);
        chk("midrst_no_done", n_done - s_done, 0);
        s_rd = n_rd; s_err = addr_err; s_win = n_win;
        run(12'd20, 8'd8, 8'd1, 3'd3, 3'd1);
        wait_done("restart");
        @(negedge clk);
        chk("restart_reads", n_rd - s_rd, 8);
        chk("restart_wins", n_win - s_win, 6);
        chk("restart_addr_err", addr_err - s_err, 0);

        // Starts while busy and in DONE are ignored.
        s_rd = n_rd; s_err = addr_err; s_done = n_done;
        run(12'd0, 8'd4, 8'd1, 3'd5, 3'd1);
        repeat (2) @(negedge clk);
        base = 12'd50; width = 8'd8; fill = 3'd1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done("busy_start");
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("done_start_busy", int'(busy1), 0);
        @(negedge clk);
        chk("done_start_idle", int'(busy1), 0);
        chk("busy_start_reads", n_rd - s_rd, 4);
        chk("busy_start_addr_err", addr_err - s_err, 0);
        chk("busy_start_dones", n_done - s_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
